// File: rtl/pal_cfg_loader_if.sv
// rtl/pal_cfg_loader_if.sv - configuration word handshake between word source and loader
interface pal_cfg_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] WORD_IN;
    logic              WORD_VALID;
    logic              WORD_READY;

    // Word source side
    modport master (
        output WORD_IN,
        output WORD_VALID,
        input  WORD_READY
    );

    // Loader side
    modport slave (
        input  WORD_IN,
        input  WORD_VALID,
        output WORD_READY
    );
endinterface

// File: rtl/pal_cfg_loader.sv
// rtl/pal_cfg_loader.sv - serialises configuration words MSB-first into a PAL shift register
module pal_cfg_loader #(
    parameter int N      = 4,
    parameter int M      = 1,
    parameter int P      = 3,
    parameter int WORD_W = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic                   ABORT,
    pal_cfg_loader_if.slave        word_if,
    output logic                   CFG,
    output logic                   SHIFT_EN,
    output logic                   BUSY,
    output logic                   DONE
);
    localparam int SR_LEN = 2 * N * P + P * M;
    localparam int TC_W   = $clog2(SR_LEN + 1);
    localparam int BC_W   = $clog2(WORD_W + 1);

    localparam logic [TC_W-1:0] SR_LEN_C = TC_W'(SR_LEN);
    localparam logic [BC_W-1:0] WORD_W_C = BC_W'(WORD_W);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_WORD = 2'd1,
        SHIFT     = 2'd2,
        FINISH    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [TC_W-1:0]   total_cnt_q, total_cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              shift_en_q, shift_en_d;
    logic              done_q, done_d;

    logic              accept;
    logic [BC_W-1:0]   bit_inc;
    logic [TC_W-1:0]   total_inc;

    // ABORT masks READY combinationally so no word is taken in the abort cycle
    assign word_if.WORD_READY = ready_q & ~ABORT;
    assign accept             = word_if.WORD_READY & word_if.WORD_VALID;
    assign bit_inc            = bit_cnt_q + BC_W'(1);
    assign total_inc          = total_cnt_q + TC_W'(1);

    assign CFG      = shift_en_q & word_q[WORD_W-1];
    assign SHIFT_EN = shift_en_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

    // Next-state logic; outputs are decoded from the next state so they come straight off flops
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        total_cnt_d = total_cnt_q;
        word_d      = word_q;

        case (state_q)
            IDLE: begin
                if (START && !ABORT) begin
                    state_d     = WAIT_WORD;
                    bit_cnt_d   = '0;
                    total_cnt_d = '0;
                end
            end
            WAIT_WORD: begin
                if (ABORT) begin
                    state_d = IDLE;
                end else if (accept) begin
                    word_d  = word_if.WORD_IN;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ABORT) begin
                    state_d = IDLE;
                end else begin
                    word_d      = word_q << 1;
                    bit_cnt_d   = bit_inc;
                    total_cnt_d = total_inc;
                    // Total length wins so the tail of a partial last word is dropped
                    if (total_inc == SR_LEN_C) begin
                        state_d = FINISH;
                    end else if (bit_inc == WORD_W_C) begin
                        state_d   = WAIT_WORD;
                        bit_cnt_d = '0;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d     = (state_d != IDLE);
        ready_d    = (state_d == WAIT_WORD);
        shift_en_d = (state_d == SHIFT);
        done_d     = (state_d == FINISH);
    end

    // State, counters, word register and registered outputs with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            total_cnt_q <= '0;
            word_q      <= '0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            shift_en_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            total_cnt_q <= total_cnt_d;
            word_q      <= word_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            shift_en_q  <= shift_en_d;
            done_q      <= done_d;
        end
    end
endmodule

// File: tb/tb_pal_cfg_loader.sv
// tb/tb_pal_cfg_loader.sv - self-checking bench for pal_cfg_loader
module tb_pal_cfg_loader;
    localparam int N  = 4;
    localparam int M  = 1;
    localparam int P  = 3;
    localparam int W  = 8;
    localparam int SR = 2 * N * P + P * M;
    localparam int NW = (SR + W - 1) / W;

    logic CLK = 1'b0;
    logic RST, START, ABORT, CFG, SHIFT_EN, BUSY, DONE;

    pal_cfg_loader_if #(.WORD_W(W)) wif ();

    pal_cfg_loader #(.N(N), .M(M), .P(P), .WORD_W(W)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .ABORT    (ABORT),
        .word_if  (wif.slave),
        .CFG      (CFG),
        .SHIFT_EN (SHIFT_EN),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    logic [W-1:0]  words [NW];
    int            gaps  [NW];

    logic [63:0]   sh_obs;
    logic [SR-1:0] bits_obs;
    int            acc_obs [$];
    int            done_cnt;
    int            done_at;
    int            cfg_bad;

    logic [63:0]   sh_exp;
    logic [SR-1:0] bits_exp;
    int            acc_exp [NW];
    int            done_exp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            START = 1'b0;
            ABORT = 1'b0;
            RST   = 1'b0;
            wif.WORD_VALID = 1'b0;
        end
    endtask

    // Reference timeline: one WAIT_WORD cycle per word plus its stall, then one SHIFT per kept bit
    task automatic model();
        int cur;
        int rem;
        int len;
        sh_exp = '0;
        cur = 1;
        rem = SR;
        for (int i = 0; i < NW; i++) begin
            cur = cur + gaps[i];
            acc_exp[i] = cur;
            len = (rem < W) ? rem : W;
            for (int j = 1; j <= len; j++) sh_exp[cur + j] = 1'b1;
            rem = rem - len;
            cur = cur + len + 1;
        end
        done_exp = cur;
        for (int b = 0; b < SR; b++) begin
            bits_exp[SR - 1 - b] = words[b / W][W - 1 - (b % W)];
        end
    endtask

    // Cycle k=0 is the START cycle; inputs driven on negedge, outputs sampled shortly after
    task automatic do_load(input int abort_at, input int rst_at, input int again_at, input int limit);
        int  widx;
        int  stall;
        logic rdy;
        sh_obs   = '0;
        bits_obs = '0;
        acc_obs.delete();
        done_cnt = 0;
        done_at  = -1;
        cfg_bad  = 0;
        widx     = 0;
        stall    = 0;
        for (int k = 0; k < limit; k++) begin
            @(negedge CLK);
            START = (k == 0) || (k == again_at);
            ABORT = (k == abort_at);
            RST   = (k == rst_at);
            #1;
            rdy = wif.WORD_READY;
            if (widx < NW && rdy && stall < gaps[widx]) begin
                wif.WORD_VALID = 1'b0;
                stall++;
            end else if (widx < NW) begin
                wif.WORD_VALID = 1'b1;
                wif.WORD_IN    = words[widx];
            end else begin
                wif.WORD_VALID = 1'b0;
            end
            #1;
            if (wif.WORD_READY && wif.WORD_VALID) begin
                acc_obs.push_back(k);
                widx++;
                stall = 0;
            end
            if (SHIFT_EN) begin
                sh_obs[k] = 1'b1;
                bits_obs  = {bits_obs[SR-2:0], CFG};
            end else if (CFG !== 1'b0) begin
                cfg_bad++;
            end
            if (DONE) begin
                done_cnt++;
                done_at = k;
            end
            if (abort_at >= 0 && k == abort_at + 1) begin
                chk("abort_shift_en", 64'(SHIFT_EN), 64'd0);
                chk("abort_busy", 64'(BUSY), 64'd0);
            end
            if (rst_at >= 0 && k == rst_at + 1) begin
                chk("rst_outputs", {59'd0, BUSY, wif.WORD_READY, SHIFT_EN, CFG, DONE}, 64'd0);
            end
        end
    endtask

    task automatic check_load(input string tag);
        model();
        chk({tag, "_shift_cycles"}, sh_obs, sh_exp);
        chk({tag, "_bits"}, 64'(bits_obs), 64'(bits_exp));
        chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        chk({tag, "_done_at"}, 64'(done_at), 64'(done_exp));
        chk({tag, "_acc_cnt"}, 64'(acc_obs.size()), 64'(NW));
        for (int i = 0; i < NW && i < acc_obs.size(); i++) begin
            chk({tag, "_acc"}, 64'(acc_obs[i]), 64'(acc_exp[i]));
        end
        chk({tag, "_cfg_idle_zero"}, 64'(cfg_bad), 64'd0);
    endtask

    initial begin
        RST = 1'b1;
        START = 1'b0;
        ABORT = 1'b0;
        wif.WORD_VALID = 1'b0;
        wif.WORD_IN    = '0;
        for (int i = 0; i < NW; i++) gaps[i] = 0;

        // Reset state
        repeat (3) @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        #1;
        chk("reset_outputs", {59'd0, BUSY, wif.WORD_READY, SHIFT_EN, CFG, DONE}, 64'd0);
        START = 1'b0;
        RST   = 1'b0;
        idle(2);
        #1;
        chk("reset_release_idle", {59'd0, BUSY, wif.WORD_READY, SHIFT_EN, CFG, DONE}, 64'd0);

        // Directed load, WORD_VALID held high
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF; words[3] = 8'h80;
        do_load(-1, -1, -1, 40);
        check_load("basic");
        idle(2);

        // Five-cycle stall before the third word
        gaps[2] = 5;
        do_load(-1, -1, -1, 45);
        check_load("stall");
        gaps[2] = 0;
        idle(2);

        // START pulse mid-load is ignored
        do_load(-1, -1, 5, 40);
        check_load("restart_ignored");
        idle(2);

        // ABORT mid-shift, then a fresh load starting two cycles later
        do_load(14, -1, -1, 16);
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        words[0] = 8'h5A; words[1] = 8'hC3; words[2] = 8'h0F; words[3] = 8'hE0;
        do_load(-1, -1, -1, 40);
        check_load("after_abort");
        idle(2);

        // Reset mid-load discards everything
        do_load(-1, 20, -1, 40);
        chk("rst_no_done", 64'(done_cnt), 64'd0);
        idle(2);

        // START together with ABORT in IDLE does nothing
        @(negedge CLK);
        START = 1'b1;
        ABORT = 1'b1;
        idle(1);
        #1;
        chk("start_abort_busy", 64'(BUSY), 64'd0);
        chk("start_abort_ready", 64'(wif.WORD_READY), 64'd0);
        idle(3);
        #1;
        chk("start_abort_still_idle", {62'd0, BUSY, SHIFT_EN}, 64'd0);

        // Randomised words and stalls
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NW; i++) begin
                words[i] = W'($urandom);
                gaps[i]  = int'($urandom_range(0, 3));
            end
            do_load(-1, -1, -1, 50);
            check_load("random");
            idle(2);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
